// File: rtl/spart_core.sv
// Programmable UART core: processor bus registers, baud generator,
// and 8N1 transmitter/receiver with x16 oversampling.
module spart_core (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic       txd,
    input  logic       rxd
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic        wr_tx, rd_rx, wr_dl, wr_dh;
    logic [15:0] divisor, baud_cnt;
    logic        tick;
    logic [7:0]  rd_data, rx_buf;

    assign wr_tx = iocs && !iorw && (ioaddr == 2'b00);
    assign rd_rx = iocs && iorw && (ioaddr == 2'b00);
    assign wr_dl = iocs && !iorw && (ioaddr == 2'b10);
    assign wr_dh = iocs && !iorw && (ioaddr == 2'b11);

    always_comb begin
        rd_data = 8'h00;
        unique case (ioaddr)
            2'b00: rd_data = rx_buf;
            2'b01: rd_data = {6'b0, tbr, rda};
            2'b10: rd_data = divisor[7:0];
            2'b11: rd_data = divisor[15:8];
            default: rd_data = 8'h00;
        endcase
    end

    assign databus = (iocs && iorw) ? rd_data : 8'hzz;

    // A divisor write restarts the baud period from the new value.
    always_ff @(posedge clk) begin
        if (rst) begin
            divisor  <= 16'h028A;
            baud_cnt <= 16'h028A;
        end else if (wr_dl) begin
            divisor[7:0] <= databus;
            baud_cnt     <= {divisor[15:8], databus};
        end else if (wr_dh) begin
            divisor[15:8] <= databus;
            baud_cnt      <= {databus, divisor[7:0]};
        end else if (baud_cnt == 16'd0) begin
            baud_cnt <= divisor;
        end else begin
            baud_cnt <= baud_cnt - 16'd1;
        end
    end

    assign tick = (baud_cnt == 16'd0);

    state_t      tx_state, tx_state_n;
    logic [3:0]  tx_tick, tx_tick_n;
    logic [2:0]  tx_bit, tx_bit_n;
    logic [7:0]  tx_shift, tx_shift_n;
    logic        txd_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= S_IDLE;
            tx_tick  <= 4'd0;
            tx_bit   <= 3'd0;
            tx_shift <= 8'h00;
            txd      <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_tick  <= tx_tick_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            txd      <= txd_n;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_tick_n  = tx_tick;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        unique case (tx_state)
            S_IDLE: if (wr_tx) begin
                tx_state_n = S_START;
                tx_shift_n = databus;
                tx_tick_n  = 4'd0;
                tx_bit_n   = 3'd0;
            end
            S_START: if (tick) begin
                tx_tick_n = tx_tick + 4'd1;
                if (tx_tick == 4'd15) tx_state_n = S_DATA;
            end
            S_DATA: if (tick) begin
                tx_tick_n = tx_tick + 4'd1;
                if (tx_tick == 4'd15) begin
                    if (tx_bit == 3'd7) begin
                        tx_state_n = S_STOP;
                    end else begin
                        tx_shift_n = {1'b0, tx_shift[7:1]};
                        tx_bit_n   = tx_bit + 3'd1;
                    end
                end
            end
            S_STOP: if (tick) begin
                tx_tick_n = tx_tick + 4'd1;
                if (tx_tick == 4'd15) tx_state_n = S_IDLE;
            end
            default: tx_state_n = S_IDLE;
        endcase
        // Line level follows the next state so txd is a clean flop output.
        txd_n = 1'b1;
        if (tx_state_n == S_START) txd_n = 1'b0;
        if (tx_state_n == S_DATA)  txd_n = tx_shift_n[0];
    end

    assign tbr = (tx_state == S_IDLE);

    state_t      rx_state, rx_state_n;
    logic [3:0]  rx_tick, rx_tick_n;
    logic [2:0]  rx_bit, rx_bit_n;
    logic [7:0]  rx_shift, rx_shift_n;
    logic        rx_s1, rx_s2, rx_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_state <= S_IDLE;
            rx_tick  <= 4'd0;
            rx_bit   <= 3'd0;
            rx_shift <= 8'h00;
            rx_buf   <= 8'h00;
            rda      <= 1'b0;
        end else begin
            rx_s1    <= rxd;
            rx_s2    <= rx_s1;
            rx_state <= rx_state_n;
            rx_tick  <= rx_tick_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
            if (rx_done) begin
                rx_buf <= rx_shift;
                rda    <= 1'b1;
            end else if (rd_rx) begin
                rda <= 1'b0;
            end
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_tick_n  = rx_tick;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_done    = 1'b0;
        unique case (rx_state)
            S_IDLE: if (tick && !rx_s2) begin
                rx_state_n = S_START;
                rx_tick_n  = 4'd0;
            end
            S_START: if (tick) begin
                rx_tick_n = rx_tick + 4'd1;
                if (rx_tick == 4'd7) begin
                    rx_tick_n  = 4'd0;
                    rx_bit_n   = 3'd0;
                    rx_state_n = rx_s2 ? S_IDLE : S_DATA;
                end
            end
            S_DATA: if (tick) begin
                rx_tick_n = rx_tick + 4'd1;
                if (rx_tick == 4'd15) begin
                    rx_shift_n = {rx_s2, rx_shift[7:1]};
                    rx_bit_n   = rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_state_n = S_STOP;
                end
            end
            S_STOP: if (tick) begin
                rx_tick_n = rx_tick + 4'd1;
                if (rx_tick == 4'd15) begin
                    rx_state_n = S_IDLE;
                    rx_done    = rx_s2;
                end
            end
            default: rx_state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_spart_core.sv
// Bench for spart_core: register access, TX/RX framing at divisor 1,
// framing error, glitch rejection, overrun and mid-frame reset.
module tb_spart_core;

    logic       clk = 1'b0;
    logic       rst, iocs, iorw, rxd;
    logic [1:0] ioaddr;
    wire  [7:0] databus;
    logic       rda, tbr, txd;
    logic [7:0] bus_drv;
    logic       bus_oe;

    assign databus = bus_oe ? bus_drv : 8'hzz;

    spart_core dut (
        .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw),
        .ioaddr(ioaddr), .databus(databus), .rda(rda),
        .tbr(tbr), .txd(txd), .rxd(rxd)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int d_edge = 0;
    logic       exp_rda;
    logic [7:0] exp_buf;
    logic [7:0] v, r;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        iocs = 1'b1; iorw = 1'b0; ioaddr = a;
        bus_drv = d; bus_oe = 1'b1;
        cycles(1);
        iocs = 1'b0; bus_oe = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] d);
        iocs = 1'b1; iorw = 1'b1; ioaddr = a;
        #1;
        d = databus;
        cycles(1);
        iocs = 1'b0; iorw = 1'b0;
    endtask

    // Baud ticks at divisor 1 fall on even edges after the divisor write.
    task automatic set_div(input logic [7:0] lo, input logic [7:0] hi);
        wr(2'b10, lo);
        wr(2'b11, hi);
        d_edge = cyc;
    endtask

    task automatic tx_frame(input logic [7:0] d, input bit inject,
                            input logic [7:0] junk);
        logic [9:0] fr;
        int gap;
        fr = {1'b1, d, 1'b0};
        if (((cyc + 1 - d_edge) % 2) != 0) cycles(1);
        check("tx_idle_txd", {7'b0, txd}, 8'h01);
        check("tx_idle_tbr", {7'b0, tbr}, 8'h01);
        wr(2'b00, d);
        check("tx_tbr_fall", {7'b0, tbr}, 8'h00);
        gap = 16;
        for (int k = 0; k < 10; k++) begin
            cycles(gap);
            check($sformatf("txd_bit%0d", k), {7'b0, txd}, {7'b0, fr[k]});
            gap = 32;
            if (inject && k == 3) begin
                wr(2'b00, junk);
                gap = 31;
            end
        end
        cycles(15);
        check("tbr_at_319", {7'b0, tbr}, 8'h00);
        cycles(1);
        check("tbr_at_320", {7'b0, tbr}, 8'h01);
    endtask

    task automatic rx_frame(input logic [7:0] d, input logic stop_bit);
        logic [9:0] fr;
        fr = {stop_bit, d, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rxd = fr[k];
            cycles(32);
        end
        rxd = 1'b1;
        if (stop_bit) begin
            exp_buf = d;
            exp_rda = 1'b1;
        end
        cycles(40);
    endtask

    task automatic rx_read_check(input string tag);
        check({tag, "_rda"}, {7'b0, rda}, {7'b0, exp_rda});
        rd(2'b00, v);
        check({tag, "_data"}, v, exp_buf);
        exp_rda = 1'b0;
        check({tag, "_rda_clr"}, {7'b0, rda}, {7'b0, exp_rda});
    endtask

    initial begin
        rst = 1'b1; iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00;
        rxd = 1'b1; bus_oe = 1'b0; bus_drv = 8'h00;
        cycles(3);
        rst = 1'b0;
        exp_rda = 1'b0;
        exp_buf = 8'h00;

        check("rst_txd", {7'b0, txd}, 8'h01);
        check("rst_tbr", {7'b0, tbr}, 8'h01);
        check("rst_rda", {7'b0, rda}, 8'h00);
        rd(2'b01, v); check("rst_status", v, 8'h02);
        rd(2'b10, v); check("rst_div_lo", v, 8'h8A);
        rd(2'b11, v); check("rst_div_hi", v, 8'h02);
        rd(2'b00, v); check("rst_rxbuf", v, 8'h00);
        wr(2'b01, 8'hFF);
        rd(2'b01, v); check("nop_status", v, 8'h02);

        set_div(8'h01, 8'h00);
        rd(2'b10, v); check("div_lo", v, 8'h01);
        rd(2'b11, v); check("div_hi", v, 8'h00);

        tx_frame(8'hA5, 1'b0, 8'h00);
        r = 8'($urandom);
        tx_frame(r, 1'b0, 8'h00);
        r = 8'($urandom);
        tx_frame(r, 1'b1, ~r);

        rx_frame(8'h3C, 1'b1);
        rx_read_check("rx_3c");
        for (int i = 0; i < 3; i++) begin
            rx_frame(8'($urandom), 1'b1);
            rx_read_check("rx_rand");
        end

        rx_frame(8'($urandom), 1'b0);
        check("frame_err_rda", {7'b0, rda}, {7'b0, exp_rda});
        rd(2'b00, v); check("frame_err_buf", v, exp_buf);

        rxd = 1'b0;
        cycles(2);
        rxd = 1'b1;
        cycles(400);
        check("glitch_rda", {7'b0, rda}, 8'h00);

        rx_frame(8'h11, 1'b1);
        rx_frame(8'h22, 1'b1);
        rx_read_check("overrun");

        wr(2'b00, 8'h5A);
        cycles(100);
        check("midtx_tbr", {7'b0, tbr}, 8'h00);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        check("abort_txd", {7'b0, txd}, 8'h01);
        check("abort_tbr", {7'b0, tbr}, 8'h01);
        rd(2'b10, v); check("abort_div_lo", v, 8'h8A);
        rd(2'b00, v); check("abort_rxbuf", v, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
